// File: rtl/palette_fade_ctrl.sv
// Brightness-scaled shadow palette with vblank-paced fade sequencing.
// The shadow copy is rewritten one entry per clock during vertical blank.
module palette_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned LEVEL_STEP      = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_base_color [0:15],
  input  logic        i_start,
  input  logic        i_dir,
  input  logic        i_vblank,
  input  logic [3:0]  i_rd_idx,
  output logic [23:0] o_rd_color,
  output logic [4:0]  o_level,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    UPDATE
  } state_t;

  state_t      state;
  logic [4:0]  target;
  logic [3:0]  fcnt;
  logic [3:0]  ptr;
  logic        vb_d;
  logic [23:0] shadow [0:15];

  logic        vb_edge;
  logic [4:0]  start_target;
  logic [4:0]  next_level;
  logic [23:0] wdata;

  localparam logic [4:0] STEP     = 5'(LEVEL_STEP);
  localparam logic [3:0] FCNT_LST = 4'(FRAMES_PER_STEP - 1);

  function automatic logic [7:0] chan_scale(input logic [7:0] c, input logic [4:0] lvl);
    return 8'((12'(c) * 12'(lvl)) >> 4);
  endfunction

  assign vb_edge      = i_vblank && !vb_d;
  assign start_target = i_dir ? 5'd16 : 5'd0;

  // Step toward the target, landing exactly on it when the remaining gap is within one step.
  always_comb begin
    next_level = o_level;
    if (target > o_level) begin
      next_level = ((target - o_level) <= STEP) ? target : o_level + STEP;
    end else if (target < o_level) begin
      next_level = ((o_level - target) <= STEP) ? target : o_level - STEP;
    end
  end

  always_comb begin
    wdata = '0;
    if (ptr != 4'd0) begin
      wdata = {chan_scale(i_base_color[ptr][23:16], o_level),
               chan_scale(i_base_color[ptr][15:8],  o_level),
               chan_scale(i_base_color[ptr][7:0],   o_level)};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      target     <= '0;
      fcnt       <= '0;
      ptr        <= '0;
      vb_d       <= 1'b1;
      o_level    <= '0;
      o_rd_color <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      vb_d       <= i_vblank;
      o_done     <= 1'b0;
      o_rd_color <= shadow[i_rd_idx];
      case (state)
        IDLE: begin
          if (i_start) begin
            if (start_target != o_level) begin
              target <= start_target;
              fcnt   <= '0;
              o_busy <= 1'b1;
              state  <= WAIT_VB;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        WAIT_VB: begin
          if (vb_edge) begin
            if (fcnt == FCNT_LST) begin
              fcnt    <= '0;
              o_level <= next_level;
              ptr     <= '0;
              state   <= UPDATE;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
        end
        UPDATE: begin
          shadow[ptr] <= wdata;
          ptr         <= ptr + 4'd1;
          if (ptr == 4'd15) begin
            if (o_level == target) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= WAIT_VB;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
